// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Size codes, FSM states and byte-enable helpers for load_store_unit
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] size_be(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return BE_BYTE;
            2'b01:   return BE_HALF;
            default: return BE_WORD;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // An access is misaligned exactly when its bytes spill into the next word
    function automatic logic crosses_word(input logic [2:0] f3, input logic [1:0] off);
        logic [7:0] be8;
        be8 = {4'b0000, size_be(f3)} << off;
        return |be8[7:4];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Store lane shift / byte-enable generation and load extract/extend
// Revision : 1.0
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_lo,
    input  logic [31:0] load_hi,
    output logic [7:0]  be8,
    output logic [63:0] store_lanes,
    output logic [31:0] load_data
);

    logic [3:0]  w_base_be;
    logic [31:0] w_store_mask;
    logic [31:0] w_shifted;

    // Two-word window: lower half feeds BEAT1, upper half feeds BEAT2
    always_comb begin
        w_base_be    = size_be(size);
        w_store_mask = {{8{w_base_be[3]}}, {8{w_base_be[2]}},
                        {8{w_base_be[1]}}, {8{w_base_be[0]}}};
        be8          = {4'b0000, w_base_be} << offset;
        store_lanes  = {32'd0, store_data & w_store_mask} << {offset, 3'b000};
        w_shifted    = 32'({load_hi, load_lo} >> {offset, 3'b000});
        case (size)
            F3_B:    load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   load_data = {24'd0, w_shifted[7:0]};
            F3_HU:   load_data = {16'd0, w_shifted[15:0]};
            default: load_data = w_shifted;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : RV32I load/store unit with one-beat word memory port.
//            Define MISALIGNED_SPLIT_EN to split word-crossing accesses in two beats.
// Revision : 1.0
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemWrite,
    input  logic [2:0]            AddressingControl,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  misaligned_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ack
);

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    lsu_state_t state, state_next;

    logic                  r_we;
    logic [2:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_err;
    logic [31:0]           r_lo;
    logic [DATA_WIDTH-1:0] r_rdata;

    logic                  w_req_err;
    logic                  w_accept;
    logic                  w_capture_lo;
    logic                  w_capture_rdata;
    logic [ADDR_WIDTH-1:0] w_word_addr;
    logic [31:0]           w_load_lo;
    logic [7:0]            w_be8;
    logic [63:0]           w_lanes;
    logic [31:0]           w_load_data;

    assign w_req_err   = !is_legal(MemWrite, AddressingControl) ||
                         (!SPLIT_EN && crosses_word(AddressingControl, addr[1:0]));
    assign w_word_addr = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    // The lower word comes straight off the bus unless it was parked by BEAT1
    assign w_load_lo   = (state == ST_BEAT2) ? r_lo : mem_rdata;

    lsu_lane_align u_lane_align (
        .size        (r_size),
        .offset      (r_addr[1:0]),
        .store_data  (r_wdata[31:0]),
        .load_lo     (w_load_lo),
        .load_hi     (mem_rdata),
        .be8         (w_be8),
        .store_lanes (w_lanes),
        .load_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_be          = 4'b0000;
        mem_wdata       = 32'd0;
        resp_valid      = 1'b0;
        misaligned_err  = 1'b0;
        w_accept        = 1'b0;
        w_capture_lo    = 1'b0;
        w_capture_rdata = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept   = 1'b1;
                    state_next = w_req_err ? ST_RESP : ST_BEAT1;
                end
            end
            ST_BEAT1: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_word_addr;
                mem_be    = w_be8[3:0];
                mem_wdata = w_lanes[31:0];
                if (mem_ack) begin
                    if (|w_be8[7:4]) begin
                        state_next   = ST_BEAT2;
                        w_capture_lo = 1'b1;
                    end else begin
                        state_next      = ST_RESP;
                        w_capture_rdata = !r_we;
                    end
                end
            end
            ST_BEAT2: begin
                mem_req   = 1'b1;
                mem_we    = r_we;
                mem_addr  = w_word_addr + ADDR_WIDTH'(4);
                mem_be    = w_be8[7:4];
                mem_wdata = w_lanes[63:32];
                if (mem_ack) begin
                    state_next      = ST_RESP;
                    w_capture_rdata = !r_we;
                end
            end
            ST_RESP: begin
                resp_valid     = !r_err;
                misaligned_err = r_err;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_size  <= 3'b000;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_lo    <= 32'd0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_we    <= MemWrite;
                r_size  <= AddressingControl;
                r_addr  <= addr;
                r_wdata <= wdata;
                r_err   <= w_req_err;
            end
            if (w_capture_lo)    r_lo    <= mem_rdata;
            if (w_capture_rdata) r_rdata <= w_load_data;
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Randomized scoreboard bench with a byte-addressed reference memory
// Revision : 1.0
// ============================================================================
module tb_load_store_unit;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_ready, MemWrite;
    logic [2:0]  AddressingControl;
    logic [31:0] addr, wdata, rdata;
    logic        resp_valid, misaligned_err;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .MemWrite(MemWrite), .AddressingControl(AddressingControl),
        .addr(addr), .wdata(wdata),
        .resp_valid(resp_valid), .rdata(rdata), .misaligned_err(misaligned_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          accept_cyc;
        bit          first;
    } beat_t;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          accept_cyc;
        int          nbeats;
    } resp_t;

    beat_t       beat_q[$];
    resp_t       resp_q[$];
    logic [7:0]  refmem  [bit [31:0]];
    logic [31:0] realmem [bit [31:0]];
    logic [31:0] exp_rdata = 32'd0;
    int          force_stall = -1;
    int          last_ack_cyc = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] w);
        return (w * 32'h0101_0101) ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        logic [31:0] w;
        int          sh;
        if (refmem.exists(a)) return refmem[a];
        w  = init_word(a & 32'hFFFF_FFFC);
        sh = int'(a[1:0]);
        return w[8*sh +: 8];
    endfunction

    function automatic logic [31:0] real_rd(input logic [31:0] w);
        if (realmem.exists(w)) return realmem[w];
        return init_word(w);
    endfunction

    task automatic set_word(input logic [31:0] w, input logic [31:0] v);
        realmem[w] = v;
        for (int i = 0; i < 4; i++) refmem[w + 32'(i)] = v[8*i +: 8];
    endtask

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    // Waits for ready (scribbling on the request lines while busy), then issues.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        int          n, guard;
        bit          legal, err;
        resp_t       r;
        beat_t       b1, b2;
        logic [31:0] val;
        guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1) begin
            req_valid         = 1'($urandom_range(0, 1));
            MemWrite          = 1'($urandom_range(0, 1));
            AddressingControl = 3'($urandom_range(0, 7));
            addr              = $urandom;
            wdata             = $urandom;
            guard++;
            if (guard > 100) begin
                checks++; errors++;
                $display("FAIL ready_timeout: got req_ready=0 expected 1 within 100 cycles");
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        req_valid = 1'b1; MemWrite = we; AddressingControl = f3; addr = a; wdata = d;

        n     = size_of(f3);
        legal = we ? (f3 <= 3'b010) : (n != 0);
        err   = !legal || (!SPLIT && (int'(a[1:0]) + n > 4));
        r.err = err; r.accept_cyc = cyc; r.nbeats = 0;
        if (!err) begin
            b1 = '{addr: a & 32'hFFFF_FFFC, we: we, be: 4'b0000, wdata: 32'd0,
                   accept_cyc: cyc, first: 1'b1};
            b2 = '{addr: (a & 32'hFFFF_FFFC) + 32'd4, we: we, be: 4'b0000, wdata: 32'd0,
                   accept_cyc: cyc, first: 1'b0};
            val = 32'd0;
            for (int i = 0; i < n; i++) begin
                logic [31:0] ba;
                int          lane;
                ba   = a + 32'(i);
                lane = int'(ba[1:0]);
                if ((ba & 32'hFFFF_FFFC) == b1.addr) begin
                    b1.be[lane] = 1'b1; b1.wdata[8*lane +: 8] = d[8*i +: 8];
                end else begin
                    b2.be[lane] = 1'b1; b2.wdata[8*lane +: 8] = d[8*i +: 8];
                end
                if (we) refmem[ba] = d[8*i +: 8];
                else    val[8*i +: 8] = ref_rd(ba);
            end
            if (!we && f3 == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
            if (!we && f3 == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
            if (!we) exp_rdata = val;
            beat_q.push_back(b1);
            r.nbeats = 1;
            if (b2.be != 4'b0000) begin
                beat_q.push_back(b2);
                r.nbeats = 2;
            end
        end
        r.rdata = exp_rdata;
        resp_q.push_back(r);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        req_valid = 1'b0;
        while (req_ready !== 1'b1) begin
            @(negedge clk);
            guard++;
            if (guard > 100) begin
                checks++; errors++;
                $display("FAIL idle_timeout: got req_ready=0 expected 1 within 100 cycles");
                return;
            end
        end
    endtask

    // Memory responder: checks each beat against expectations, stalls, acks.
    initial begin : responder
        bit          in_beat;
        bit          stable;
        int          stall;
        beat_t       cur;
        logic [31:0] s_addr, s_wd, w;
        logic        s_we;
        logic [3:0]  s_be;
        in_beat = 1'b0; stable = 1'b1; stall = 0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (!rst_n) begin
                in_beat = 1'b0;
                continue;
            end
            if (mem_req === 1'b1) begin
                if (!in_beat) begin
                    in_beat = 1'b1; stable = 1'b1;
                    s_addr = mem_addr; s_we = mem_we; s_be = mem_be; s_wd = mem_wdata;
                    if (beat_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat: got mem_req addr %h expected no beat", mem_addr);
                    end else begin
                        cur = beat_q.pop_front();
                        check("beat_addr", mem_addr, cur.addr);
                        check("beat_we", 32'(mem_we), 32'(cur.we));
                        check("beat_be", 32'(mem_be), 32'(cur.be));
                        if (cur.we)
                            check("beat_wdata", mem_wdata & {{8{cur.be[3]}}, {8{cur.be[2]}},
                                  {8{cur.be[1]}}, {8{cur.be[0]}}}, cur.wdata);
                        if (cur.first) check("beat_latency", 32'(cyc), 32'(cur.accept_cyc + 1));
                    end
                    stall = (force_stall >= 0) ? force_stall :
                            (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);
                end else if (mem_addr !== s_addr || mem_we !== s_we ||
                             mem_be !== s_be || mem_wdata !== s_wd) begin
                    stable = 1'b0;
                end
                if (stall == 0) begin
                    mem_ack = 1'b1;
                    w = real_rd(s_addr);
                    if (s_we) begin
                        for (int i = 0; i < 4; i++)
                            if (s_be[i]) w[8*i +: 8] = s_wd[8*i +: 8];
                        realmem[s_addr] = w;
                    end else begin
                        mem_rdata = w;
                    end
                    check("beat_stable", 32'(stable), 32'd1);
                    last_ack_cyc = cyc;
                    in_beat = 1'b0;
                end else begin
                    stall--;
                end
            end else begin
                mem_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Response monitor: pops the scoreboard whenever the unit completes.
    initial begin : monitor
        resp_t       e;
        logic [31:0] prev;
        prev = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 32'd0;
                continue;
            end
            if (resp_valid === 1'b1 || misaligned_err === 1'b1) begin
                if (resp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_resp: got resp_valid=%b err=%b expected none",
                             resp_valid, misaligned_err);
                end else begin
                    e = resp_q.pop_front();
                    check("resp_valid", 32'(resp_valid), 32'(!e.err));
                    check("misaligned_err", 32'(misaligned_err), 32'(e.err));
                    check("rdata", rdata, e.rdata);
                    check("resp_latency", 32'(cyc),
                          32'((e.nbeats == 0) ? e.accept_cyc + 1 : last_ack_cyc + 1));
                end
            end else begin
                check("rdata_hold", rdata, prev);
            end
            prev = rdata;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_err"}, 32'(misaligned_err), 32'd0);
    endtask

    initial begin : stimulus
        int guard;
        req_valid = 1'b0; MemWrite = 1'b0; AddressingControl = 3'b000;
        addr = 32'd0; wdata = 32'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        force_stall = 0;
        issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        wait_idle();
        set_word(32'h0000_0200, 32'h80FF_FFFF);
        issue(1'b0, 3'b000, 32'h0000_0203, $urandom);
        issue(1'b0, 3'b100, 32'h0000_0203, $urandom);
        issue(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234);
        wait_idle();
        force_stall = -1;

        set_word(32'h0000_00FC, 32'hAABB_CCDD);
        set_word(32'h0000_0100, 32'h1122_3344);
        issue(1'b0, 3'b010, 32'h0000_00FD, 32'd0);
        wait_idle();

        force_stall = 5;
        issue(1'b0, 3'b010, 32'h0000_0200, 32'd0);
        wait_idle();
        force_stall = -1;

        issue(1'b0, 3'b011, 32'h0000_0040, 32'd0);
        issue(1'b1, 3'b100, 32'h0000_0040, 32'h5555_5555);
        issue(1'b0, 3'b101, 32'h0000_0201, 32'd0);
        issue(1'b0, 3'b001, 32'h0000_0203, 32'd0);
        issue(1'b0, 3'b010, 32'hFFFF_FFFE, 32'd0);
        issue(1'b1, 3'b001, 32'hFFFF_FFFF, 32'hCAFE_F00D);
        issue(1'b0, 3'b010, 32'hFFFF_FFFC, 32'd0);
        wait_idle();

        // Abort a load mid-beat with an asynchronous reset
        force_stall = 20;
        issue(1'b0, 3'b010, 32'h0000_0300, 32'd0);
        guard = 0;
        while (mem_req !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("abort_beat_seen", 32'(mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        beat_q.delete();
        resp_q.delete();
        exp_rdata   = 32'd0;
        force_stall = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else                           a = 32'h0000_1000 + 32'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        check("beat_q_drained", 32'(beat_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data-path width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 SHALL have one clock and reset asynchronous active-low: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-004 SHALL have these core-side ports:
- req_valid  in  1  core access request.
- req_ready  out  1  unit can accept a request.
- MemWrite  in  1  1=store, 0=load.
- AddressingControl  in  3  RV32I funct3 size code.
- addr  in  ADDR_WIDTH  byte address.
- wdata  in  DATA_WIDTH  store data, LSB-aligned.
REQ-005 SHALL have these response ports:
- resp_valid  out  1  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  extended load result.
- misaligned_err  out  1  one-cycle error pulse.
REQ-006 SHALL have these memory-side ports:
- mem_req  out  1  beat request.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_WIDTH  word-aligned beat address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-positioned write data.
- mem_rdata  in  32  read data, valid with ack.
- mem_ack  in  1  beat complete.

Function
REQ-007 SHALL implement FSM IDLE, BEAT1, BEAT2, RESP; req_ready=1 only in IDLE; a request is accepted on req_valid&&req_ready, latching all request fields.
REQ-008 SHALL decode codes as follows: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw.
REQ-009 SHALL treat any other code as illegal: no memory beat; misaligned_err pulses in RESP with resp_valid=0.
REQ-010 SHALL be little-endian: byte lane = addr[1:0]; mem_addr = {addr[31:2],2'b00}; store data shifted to its lanes; mem_be covers exactly the accessed bytes.
REQ-011 SHALL hold mem_req and all mem_* outputs stable from BEAT entry until mem_ack is sampled high, with one beat per ack.
REQ-012 SHALL handle loads as follows: extract the addressed bytes, sign-extend for lb/lh, zero-extend for lbu/lhu; rdata updates only with resp_valid and holds otherwise.
REQ-013 SHALL classify an access as misaligned when it is half at offset 3 or word at offset 1..3; half at offset 1 fits one word and is a single beat.
REQ-014 SHALL, on the ack of the final beat, go to RESP; RESP pulses resp_valid for one cycle (loads and stores), then returns to IDLE.
REQ-015 SHALL have a latency of accept cycle T, BEAT1 at T+1, resp_valid at T+2 when ack arrives at T+1; each ack stall adds one cycle.
REQ-016 SHALL ignore mem_ack outside BEAT states and never register mem_rdata outside an acked beat.
REQ-017 SHALL ignore req_valid while busy; back-to-back requests are accepted on the cycle after RESP.

Reset
REQ-018 SHALL, on rst_n low, immediately enter IDLE; req_ready=1; mem_req, mem_we, resp_valid, misaligned_err=0; mem_addr, mem_be, mem_wdata, rdata=0.
REQ-019 SHALL abort any transaction when reset is asserted mid-access, deasserting mem_req combinationally with reset; no response is produced for the aborted request.

Configuration
REQ-020 SHALL, with MISALIGNED_SPLIT_EN defined, split misaligned accesses into BEAT1 (lower word, upper lanes) and BEAT2 (mem_addr+4, lower lanes), with addresses wrapping 0xFFFFFFFC to 0x00000000; load bytes merge in order.
REQ-021 SHALL, without MISALIGNED_SPLIT_EN, issue no beat for a misaligned access, pulse misaligned_err in RESP, and leave rdata unchanged.

Structure
REQ-022 SHALL keep the size-code localparams, FSM state enum, and be/lane helper constants in a shared package lsu_pkg.
REQ-023 SHALL contain one sub-module, lsu_lane_align: combinational store lane shift/be generation plus load extract/extend.

Verification
REQ-024 SHALL cover an aligned sw: addr=0x100, wdata=0xDEADBEEF, ack at T+1 -> mem_addr=0x100, be=1111, resp_valid at T+2.
REQ-025 SHALL cover lb sign-extension: addr=0x203, mem_rdata=0x80FFFFFF -> rdata=0xFFFFFF80; the same access as lbu -> 0x00000080.
REQ-026 SHALL cover sh: addr=0x102, wdata=0x1234 -> be=1100, mem_wdata=0x12340000.
REQ-027 SHALL cover a misaligned lw: addr=0x0FD with split enabled, words 0xAABBCCDD, 0x11223344 -> beats 0x0FC and 0x100, rdata=0x44AABBCC; with split disabled -> misaligned_err, no mem_req.
REQ-028 SHALL cover a stall and reset: mem_ack withheld 5 cycles -> outputs stable; rst_n low mid-beat -> mem_req=0 immediately, no resp_valid.
REQ-029 SHALL cover an illegal code: AddressingControl=011 load -> no mem_req; misaligned_err pulses once.
